gamma_lut_stream: RTL and testbench

- Parametrised, run-time programmable gamma correction stage for the ISP pixel stream. It replaces fixed per-gamma ROM tables.
- Each of CHANNELS colour components is mapped through its own 2^DATA_W-entry lookup table.
- Tables are double-buffered. The host loads a shadow bank, and the bank swap happens only at a frame start, so no frame shows a partly loaded table.
- Sits after colour correction and before output formatting.

---
 rtl/gamma_pkg.sv | 18 +
 rtl/gamma_lut_bank_ram.sv | 31 +++
 rtl/gamma_lut_stream.sv | 137 +++++++++++++
 tb/tb_gamma_lut_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gamma_pkg.sv
// Shared constants and types for the gamma LUT stream: defaults, bank select
// width, LUT depth helper and the commit/swap state encoding.
package gamma_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int BANK_W       = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } swap_state_e;

  function automatic int lut_depth(input int data_w);
    return 1 << data_w;
  endfunction

endpackage

// File: rtl/gamma_lut_bank_ram.sv
// Simple dual-port table RAM holding both banks of one channel's gamma curve.
// Address is {bank, index}; one synchronous write port, one registered read port.
module gamma_lut_bank_ram
  import gamma_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [BANK_W+DATA_W-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [BANK_W+DATA_W-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int DEPTH = (1 << BANK_W) * lut_depth(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gamma_lut_stream.sv
// Run-time programmable gamma correction: per-channel double-buffered LUTs,
// bank swap deferred to frame start, fixed 2-cycle pixel latency.
module gamma_lut_stream
  import gamma_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CH_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic                       bypass,
  output logic                       out_valid,
  output logic                       out_sof,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [DATA_W-1:0]          cfg_addr,
  input  logic [DATA_W-1:0]          cfg_wdata,
  input  logic                       cfg_commit,
  output logic                       cfg_pending,
  output logic                       active_bank,
  output logic                       table_valid
);

  localparam int PW = CHANNELS * DATA_W;

  swap_state_e       state_q, state_d;
  logic              active_bank_q, active_bank_d;
  logic              table_valid_q, table_valid_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sof_q, s1_sof_d;
  logic              s1_use_lut_q, s1_use_lut_d;
  logic [PW-1:0]     s1_data_q, s1_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;
  logic [PW-1:0]     out_data_q, out_data_d;
  logic [PW-1:0]     lut_rdata;
  logic              sof_beat;
  logic              wr_en;

  assign sof_beat = in_valid & in_sof;

  // A swap happens on an accepted sof when a commit is pending or arrives in
  // the same cycle; the new bank and table_valid apply to that sof pixel.
  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    table_valid_d = table_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          if (sof_beat) begin
            active_bank_d = ~active_bank_q;
            table_valid_d = 1'b1;
          end else begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (sof_beat) begin
          active_bank_d = ~active_bank_q;
          table_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en = cfg_we && (state_q == ST_IDLE) &&
                 ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    gamma_lut_bank_ram #(
      .DATA_W (DATA_W)
    ) u_ram (
      .clk   (clk),
      .we    (wr_en && (cfg_ch == CH_W'(ch))),
      .waddr ({~active_bank_q, cfg_addr}),
      .wdata (cfg_wdata),
      .raddr ({active_bank_d, in_data[ch*DATA_W +: DATA_W]}),
      .rdata (lut_rdata[ch*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    s1_valid_d   = in_valid;
    s1_sof_d     = sof_beat;
    s1_data_d    = in_valid ? in_data : s1_data_q;
    s1_use_lut_d = ~bypass & table_valid_d;
    out_valid_d  = s1_valid_q;
    out_sof_d    = s1_sof_q;
    out_data_d   = out_data_q;
    if (s1_valid_q) begin
      out_data_d = s1_use_lut_q ? lut_rdata : s1_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      active_bank_q <= 1'b0;
      table_valid_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_sof_q      <= 1'b0;
      s1_use_lut_q  <= 1'b0;
      s1_data_q     <= '0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      table_valid_q <= table_valid_d;
      s1_valid_q    <= s1_valid_d;
      s1_sof_q      <= s1_sof_d;
      s1_use_lut_q  <= s1_use_lut_d;
      s1_data_q     <= s1_data_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
      out_data_q    <= out_data_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign out_data    = out_data_q;
  assign cfg_pending = (state_q == ST_PEND);
  assign active_bank = active_bank_q;
  assign table_valid = table_valid_q;

endmodule

// File: tb/tb_gamma_lut_stream.sv
// Scoreboard bench for gamma_lut_stream: directed pixels with hand-computed
// corrected values, checked with exact output cycle stamps.
module tb_gamma_lut_stream;

  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int CHW   = 2;
  localparam int PW    = DW * CH;
  localparam int ENT_W = 16 + 1 + PW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_sof, bypass;
  logic [PW-1:0]  in_data;
  logic           out_valid, out_sof;
  logic [PW-1:0]  out_data;
  logic           cfg_we, cfg_commit;
  logic [CHW-1:0] cfg_ch;
  logic [DW-1:0]  cfg_addr, cfg_wdata;
  logic           cfg_pending, active_bank, table_valid;

  logic [15:0]      cyc = '0;
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] ent;
  int               total = 0;
  int               bad   = 0;

  gamma_lut_stream #(.DATA_W(DW), .CHANNELS(CH), .CH_W(CHW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .bypass      (bypass),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .out_data    (out_data),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_commit  (cfg_commit),
    .cfg_pending (cfg_pending),
    .active_bank (active_bank),
    .table_valid (table_valid)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  // monitor: every output beat must match the head of the expected queue,
  // including the cycle it was due in
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: got unexpected beat sof=%0d data=%h at cyc %0d, required no beat",
                 out_sof, out_data, cyc);
      end else begin
        ent = exp_q.pop_front();
        if ({cyc, out_sof, out_data} !== ent) begin
          bad++;
          $display("FAIL out_beat: got cyc=%0d sof=%0d data=%h, required cyc=%0d sof=%0d data=%h",
                   cyc, out_sof, out_data, ent[ENT_W-1 -: 16], ent[PW], ent[PW-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one pixel beat; expected result is due two edges later
  task automatic beat(input logic v, input logic s, input logic [PW-1:0] d,
                      input logic b, input logic c, input logic [PW-1:0] e);
    in_valid   = v;
    in_sof     = s;
    in_data    = d;
    bypass     = b;
    cfg_commit = c;
    if (v) exp_q.push_back({cyc + 16'd2, s, e});
    tick();
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic cfg_cycle(input logic we, input logic [CHW-1:0] ch, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic commit);
    cfg_we     = we;
    cfg_ch     = ch;
    cfg_addr   = addr;
    cfg_wdata  = wdata;
    cfg_commit = commit;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    logic           v;
    logic [PW-1:0]  d;
    logic [7:0]     pix [3];

    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; bypass = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    check("rst_active_bank", 32'(active_bank), 32'd0);
    check("rst_table_valid", 32'(table_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // passthrough before any commit
    pix[0] = 8'h10; pix[1] = 8'h80; pix[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      d = {pix[i], pix[i], pix[i]};
      beat(1'b1, (i == 0), d, 1'b0, 1'b0, d);
    end
    drain();
    check("pass_table_valid", 32'(table_valid), 32'd0);

    // load bank 1: ch0 = 255-a, ch1 = a, ch2 = a>>1
    for (int a = 0; a < 256; a++) begin
      cfg_cycle(1'b1, 2'd0, 8'(a), 8'(255 - a), 1'b0);
      cfg_cycle(1'b1, 2'd1, 8'(a), 8'(a), 1'b0);
      cfg_cycle(1'b1, 2'd2, 8'(a), 8'(a >> 1), 1'b0);
    end
    cfg_cycle(1'b1, 2'd3, 8'h40, 8'hEE, 1'b0);
    cfg_cycle(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    check("commit_pending", 32'(cfg_pending), 32'd1);
    beat(1'b1, 1'b1, 24'h404040, 1'b0, 1'b0, 24'h2040BF);
    check("swap1_active_bank", 32'(active_bank), 32'd1);
    check("swap1_table_valid", 32'(table_valid), 32'd1);
    check("swap1_pending", 32'(cfg_pending), 32'd0);
    beat(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h0000FF);
    beat(1'b1, 1'b0, 24'hFFFFFF, 1'b0, 1'b0, 24'h7FFF00);
    beat(1'b1, 1'b0, 24'h102030, 1'b0, 1'b0, 24'h0820CF);
    drain();

    // bank 0 entry 0x40 -> {0x33,0x22,0x11}; commit mid-frame
    cfg_cycle(1'b1, 2'd0, 8'h40, 8'h11, 1'b0);
    cfg_cycle(1'b1, 2'd1, 8'h40, 8'h22, 1'b0);
    cfg_cycle(1'b1, 2'd2, 8'h40, 8'h33, 1'b0);
    beat(1'b1, 1'b1, 24'h404040, 1'b0, 1'b0, 24'h2040BF);
    beat(1'b1, 1'b0, 24'h404040, 1'b0, 1'b1, 24'h2040BF);
    check("mid_pending", 32'(cfg_pending), 32'd1);
    cfg_cycle(1'b1, 2'd0, 8'h40, 8'h99, 1'b0);
    beat(1'b1, 1'b0, 24'h404040, 1'b0, 1'b0, 24'h2040BF);
    beat(1'b1, 1'b0, 24'h404040, 1'b0, 1'b0, 24'h2040BF);
    check("mid_bank_held", 32'(active_bank), 32'd1);
    beat(1'b1, 1'b1, 24'h404040, 1'b0, 1'b0, 24'h332211);
    check("swap2_pending", 32'(cfg_pending), 32'd0);
    check("swap2_active_bank", 32'(active_bank), 32'd0);

    // write to new shadow (bank 1) stays hidden until the next commit;
    // then commit coincident with sof swaps immediately
    cfg_cycle(1'b1, 2'd1, 8'h40, 8'h77, 1'b0);
    beat(1'b1, 1'b0, 24'h404040, 1'b0, 1'b0, 24'h332211);
    beat(1'b1, 1'b1, 24'h404040, 1'b0, 1'b1, 24'h2077BF);
    check("imm_swap_pending", 32'(cfg_pending), 32'd0);
    check("imm_swap_bank", 32'(active_bank), 32'd1);

    // write and commit in the same idle cycle
    cfg_cycle(1'b1, 2'd2, 8'h40, 8'h5A, 1'b1);
    check("we_commit_pending", 32'(cfg_pending), 32'd1);
    beat(1'b1, 1'b1, 24'h404040, 1'b0, 1'b0, 24'h5A2211);
    check("we_commit_bank", 32'(active_bank), 32'd0);
    drain();

    // bypass with table loaded, gapped traffic
    for (int i = 0; i < 24; i++) begin
      v = 1'($urandom_range(0, 1));
      d = PW'($urandom_range(0, 24'hFFFFFF));
      beat(v, 1'b0, d, 1'b1, 1'b0, d);
    end
    drain();

    // reset mid-frame with a pending commit
    beat(1'b1, 1'b1, 24'h404040, 1'b0, 1'b0, 24'h5A2211);
    beat(1'b1, 1'b0, 24'h404040, 1'b0, 1'b1, 24'h5A2211);
    check("pre_rst_pending", 32'(cfg_pending), 32'd1);
    beat(1'b1, 1'b0, 24'h101010, 1'b0, 1'b0, 24'h000000);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_pending", 32'(cfg_pending), 32'd0);
    check("mid_rst_table_valid", 32'(table_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    beat(1'b1, 1'b1, 24'h123456, 1'b0, 1'b0, 24'h123456);
    beat(1'b1, 1'b0, 24'hABCDEF, 1'b0, 1'b0, 24'hABCDEF);
    check("post_rst_bank", 32'(active_bank), 32'd0);
    check("post_rst_table_valid", 32'(table_valid), 32'd0);
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
